pslip_grant_sched: RTL and testbench

Per-output grant scheduler for the pSLIP request-grant-accept loop. On each iteration it:
- sequences the priority-select stage (pulses its update, waits for its ready);
- captures the highest-priority request vector;
- issues a one-hot round-robin grant and waits for the input side's accept.

The round-robin pointer advances only on an accepted grant in the first iteration, which is the iSLIP desynchronisation rule.

---
 rtl/pslip_grant_sched_if.sv | 23 ++
 rtl/pslip_grant_sched.sv | 174 +++++++++++++++++
 tb/tb_pslip_grant_sched.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pslip_grant_sched_if.sv
// Selector and grant/accept handshake bundle for one pSLIP output scheduler.
// master = scheduler side, slave = selector/input-port side.
interface pslip_grant_sched_if #(
  parameter int N = 16
);
  logic         sel_update;
  logic         sel_ready;
  logic [N-1:0] req_in;
  logic [N-1:0] gnt;
  logic         gnt_valid;
  logic         acc_valid;
  logic         acc;

  modport master (
    output sel_update, gnt, gnt_valid,
    input  sel_ready, req_in, acc_valid, acc
  );

  modport slave (
    input  sel_update, gnt, gnt_valid,
    output sel_ready, req_in, acc_valid, acc
  );
endinterface

// File: rtl/pslip_grant_sched.sv
// Per-output pSLIP grant scheduler: selector sequencing, round-robin grant,
// accept wait with timeout; pointer moves only on first-iteration accepts.
//
// state    | meaning
// ---------+------------------------------------------------------
// IDLE     | waiting for start
// LOAD     | sel_update pulse to the priority selector
// WAIT_SEL | waiting for sel_ready, captures req_in
// GRANT    | round-robin pick from the captured request vector
// WAIT_ACC | grant outstanding, waiting for accept or timeout
// DONE     | done pulse, accepted valid
module pslip_grant_sched #(
  parameter int N  = 16,
  parameter int TO = 8,
  parameter int PW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 first_iter,
  pslip_grant_sched_if.master  bus,
  output logic [PW-1:0]        ptr,
  output logic                 busy,
  output logic                 done,
  output logic                 accepted
);

  localparam int CW = (TO > 1) ? $clog2(TO) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_SEL,
    GRANT,
    WAIT_ACC,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    req_q, req_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic            gv_q, gv_d;
  logic            sel_upd_q, sel_upd_d;
  logic            done_q, done_d;
  logic            acc_q, acc_d;
  logic            first_q, first_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   win_q, win_d;
  logic [PW-1:0]   win;
  logic [PW-1:0]   idx;
  logic [PW-1:0]   ptr_inc;

  // Scan downward so the lowest rotated offset from ptr wins.
  always_comb begin
    win = '0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = PW'((int'(ptr_q) + i) % N);
      if (req_q[idx]) win = idx;
    end
  end

  assign ptr_inc = (win_q == PW'(N - 1)) ? '0 : win_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    gnt_d     = gnt_q;
    gv_d      = gv_q;
    sel_upd_d = 1'b0;
    done_d    = 1'b0;
    acc_d     = acc_q;
    first_d   = first_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    win_d     = win_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          first_d   = first_iter;
          sel_upd_d = 1'b1;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        state_d = WAIT_SEL;
      end
      WAIT_SEL: begin
        if (bus.sel_ready) begin
          req_d   = bus.req_in;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (req_q == '0) begin
          acc_d   = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          gv_d       = 1'b1;
          cnt_d      = '0;
          win_d      = win;
          state_d    = WAIT_ACC;
        end
      end
      WAIT_ACC: begin
        // A late accept in the timeout cycle still counts as an accept.
        if (bus.acc_valid) begin
          gnt_d   = '0;
          gv_d    = 1'b0;
          acc_d   = bus.acc;
          done_d  = 1'b1;
          state_d = DONE;
          if (bus.acc && first_q) ptr_d = ptr_inc;
        end else if (cnt_q == CW'(TO - 1)) begin
          gnt_d   = '0;
          gv_d    = 1'b0;
          acc_d   = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      req_q     <= '0;
      gnt_q     <= '0;
      gv_q      <= 1'b0;
      sel_upd_q <= 1'b0;
      done_q    <= 1'b0;
      acc_q     <= 1'b0;
      first_q   <= 1'b0;
      cnt_q     <= '0;
      ptr_q     <= '0;
      win_q     <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      gnt_q     <= gnt_d;
      gv_q      <= gv_d;
      sel_upd_q <= sel_upd_d;
      done_q    <= done_d;
      acc_q     <= acc_d;
      first_q   <= first_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
    end
  end

  assign bus.sel_update = sel_upd_q;
  assign bus.gnt        = gnt_q;
  assign bus.gnt_valid  = gv_q;
  assign ptr            = ptr_q;
  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign accepted       = acc_q;

endmodule

// File: tb/tb_pslip_grant_sched.sv
// Scoreboard bench for pslip_grant_sched: expected grant/accept/pointer/grant
// duration pushed per iteration, popped and compared when done pulses.
module tb_pslip_grant_sched;

  localparam int N  = 16;
  localparam int TO = 8;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          first_iter = 1'b0;
  logic [PW-1:0] ptr;
  logic          busy;
  logic          done;
  logic          accepted;

  pslip_grant_sched_if #(.N(N)) bus ();

  pslip_grant_sched #(.N(N), .TO(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .first_iter (first_iter),
    .bus        (bus.master),
    .ptr        (ptr),
    .busy       (busy),
    .done       (done),
    .accepted   (accepted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  gnt;
    logic          acc;
    logic [PW-1:0] ptr;
    int            gv;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  int            gv_run = 0;
  logic [N-1:0]  run_gnt = '0;
  int            done_cnt = 0;
  int            sel_cnt = 0;
  int            bad_gnt = 0;
  logic [N-1:0]  d_gnt = '0;
  int            d_gv = 0;
  logic          d_acc = 1'b0;
  logic [PW-1:0] d_ptr = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: grant duration, captured grant and iteration results.
  always @(negedge clk) begin
    if (!reset) begin
      gv_run  <= 0;
      run_gnt <= '0;
    end else begin
      if (bus.gnt_valid) begin
        gv_run  <= gv_run + 1;
        run_gnt <= bus.gnt;
      end
      if (done) begin
        done_cnt <= done_cnt + 1;
        d_gnt    <= run_gnt;
        d_gv     <= gv_run;
        d_acc    <= accepted;
        d_ptr    <= ptr;
        gv_run   <= 0;
        run_gnt  <= '0;
      end
      if (bus.sel_update) sel_cnt <= sel_cnt + 1;
      if ($countones(bus.gnt) > 1 || (!bus.gnt_valid && bus.gnt != '0)) bad_gnt <= bad_gnt + 1;
    end
  end

  task automatic run_iter(input logic f, input logic [N-1:0] req, input int k,
                          input int acc_at, input logic a, input logic extra_start,
                          input logic [N-1:0] eg, input logic ea,
                          input logic [PW-1:0] ep, input int egv);
    exp_t e;
    int   d0;
    e.gnt = eg;
    e.acc = ea;
    e.ptr = ep;
    e.gv  = egv;
    sb.push_back(e);
    d0 = done_cnt;

    @(posedge clk); #1;
    start = 1'b1;
    first_iter = f;
    @(posedge clk); #1;
    start = 1'b0;
    first_iter = ~f;
    check("sel_update_rise", 32'(bus.sel_update), 1);
    check("busy_high", 32'(busy), 1);
    @(posedge clk); #1;
    check("sel_update_pulse", 32'(bus.sel_update), 0);
    for (int i = 0; i < k; i++) begin
      if (extra_start && i == 0) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    bus.sel_ready = 1'b1;
    bus.req_in    = req;
    @(posedge clk); #1;
    bus.sel_ready = 1'b0;
    bus.req_in    = N'($urandom);
    @(posedge clk); #1;
    if (req == '0) begin
      check("empty_done_lat", 32'(done), 1);
      check("empty_no_gv", 32'(bus.gnt_valid), 0);
    end else begin
      check("gnt_valid_rise", 32'(bus.gnt_valid), 1);
      if (acc_at > 0) begin
        for (int i = 1; i < acc_at; i++) begin
          @(posedge clk); #1;
        end
        bus.acc_valid = 1'b1;
        bus.acc       = a;
        @(posedge clk); #1;
        bus.acc_valid = 1'b0;
        bus.acc       = 1'b0;
      end
    end

    for (int i = 0; i < 40 && done_cnt == d0; i++) @(posedge clk);
    #1;
    e = sb.pop_front();
    if (done_cnt == d0) begin
      check("done_timeout", 0, 1);
    end else begin
      check("gnt", 32'(d_gnt), 32'(e.gnt));
      check("accepted", 32'(d_acc), 32'(e.acc));
      check("ptr", 32'(d_ptr), 32'(e.ptr));
      check("gnt_valid_cycles", 32'(d_gv), 32'(e.gv));
      check("done_pulse", 32'(done), 0);
      check("accepted_hold", 32'(accepted), 32'(e.acc));
      check("busy_idle", 32'(busy), 0);
    end
  endtask

  initial begin
    int d_before;
    int s_before;

    bus.sel_ready = 1'b0;
    bus.req_in    = '0;
    bus.acc_valid = 1'b0;
    bus.acc       = 1'b0;

    #12;
    check("rst_ptr", 32'(ptr), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_gnt", 32'(bus.gnt), 0);
    check("rst_gnt_valid", 32'(bus.gnt_valid), 0);
    check("rst_done", 32'(done), 0);
    check("rst_accepted", 32'(accepted), 0);
    check("rst_sel_update", 32'(bus.sel_update), 0);
    @(posedge clk); #1;
    reset = 1'b1;

    //        f  req        k  acc_at a  xs  exp_gnt    ea  ep  egv
    run_iter(1, 16'h0090, 0, 1, 1, 0, 16'h0010, 1, 5,  1);
    run_iter(1, 16'h0004, 1, 1, 1, 0, 16'h0004, 1, 3,  1);
    run_iter(0, 16'h0100, 0, 2, 1, 0, 16'h0100, 1, 3,  2);
    run_iter(1, 16'h2000, 0, 1, 1, 0, 16'h2000, 1, 14, 1);
    run_iter(1, 16'h0003, 0, 1, 1, 0, 16'h0001, 1, 1,  1);
    run_iter(1, 16'h4000, 0, 1, 1, 0, 16'h4000, 1, 15, 1);
    run_iter(1, 16'h8000, 0, 1, 1, 0, 16'h8000, 1, 0,  1);
    run_iter(1, 16'h0030, 0, 1, 0, 0, 16'h0010, 0, 0,  1);
    run_iter(1, 16'h0001, 0, 0, 0, 0, 16'h0001, 0, 0,  8);
    run_iter(1, 16'h0002, 0, 8, 1, 0, 16'h0002, 1, 2,  8);
    run_iter(1, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 2,  0);

    d_before = done_cnt;
    s_before = sel_cnt;
    run_iter(0, 16'h0010, 2, 1, 1, 1, 16'h0010, 1, 2,  1);
    repeat (4) @(posedge clk);
    #1;
    check("ignored_start_done", 32'(done_cnt - d_before), 1);
    check("ignored_start_sel", 32'(sel_cnt - s_before), 1);

    // Reset while a grant is outstanding.
    @(posedge clk); #1;
    start = 1'b1;
    first_iter = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    bus.sel_ready = 1'b1;
    bus.req_in    = 16'h0040;
    @(posedge clk); #1;
    bus.sel_ready = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_gnt_valid", 32'(bus.gnt_valid), 1);
    check("pre_rst_gnt", 32'(bus.gnt), 32'h0040);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("async_rst_gnt", 32'(bus.gnt), 0);
    check("async_rst_gnt_valid", 32'(bus.gnt_valid), 0);
    check("async_rst_ptr", 32'(ptr), 0);
    check("async_rst_busy", 32'(busy), 0);
    @(posedge clk); #1;
    reset = 1'b1;

    run_iter(1, 16'h0008, 0, 1, 1, 0, 16'h0008, 1, 4,  1);
    run_iter(1, 16'h0001, 3, 1, 1, 0, 16'h0001, 1, 1,  1);

    repeat (3) @(posedge clk);
    #1;
    check("total_done", 32'(done_cnt), 14);
    check("total_sel_update", 32'(sel_cnt), 15);
    check("gnt_onehot", 32'(bad_gnt), 0);
    check("sb_empty", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

endmodule
